calc_axil_slave: RTL and testbench

AXI4-Lite responder holding the calculator's operand, control, status and result registers, plus the arithmetic engine behind them. It sits between the PS master (AXI interconnect) and the calc datapath and answers single-beat reads and writes. Add, subtract and multiply complete in one cycle; unsigned divide is iterative.

---
 rtl/calc_axil_slave_if.sv | 51 +++++
 rtl/calc_axil_slave.sv | 170 +++++++++++++++++
 tb/tb_calc_axil_slave.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/calc_axil_slave_if.sv
// rtl/calc_axil_slave_if.sv - AXI4-Lite bus bundle between the PS master and the calc register block.
interface calc_axil_slave_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/calc_axil_slave.sv
// rtl/calc_axil_slave.sv - AXI4-Lite calculator registers with add/sub/mul and iterative unsigned divide.
module calc_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int DIV_CYCLES         = 32
) (
  input  logic              ACLK,
  input  logic              ARESET,
  calc_axil_slave_if.slave  s_axi,
  output logic              irq
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int CW = $clog2(DIV_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, EXEC, DIV} state_t;

  state_t        state_q;
  logic          awready_q, bvalid_q, arready_q, rvalid_q;
  logic [DW-1:0] rdata_q, opa_q, opb_q, a_q, b_q, result_q, quo_q, rem_q;
  logic [1:0]    op_q, op_lat_q;
  logic          ie_q, busy_q, done_q, div0_q;
  logic [CW-1:0] cnt_q;

  logic          wr_fire_d, rd_fire_d, start_d;
  logic [2:0]    wr_word_d, rd_word_d;
  logic [1:0]    op_d;
  logic [DW-1:0] rd_mux_d;
  logic [DW:0]   rem_shift_d, diff_d;
  logic          unused_ok;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                          input logic [DW-1:0] new_v,
                                          input logic [DW/8-1:0] strb);
    logic [DW-1:0] r;
    r = old_v;
    for (int i = 0; i < DW/8; i++)
      if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    return r;
  endfunction

  always_comb begin
    wr_fire_d   = awready_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
    rd_fire_d   = arready_q & s_axi.S_AXI_ARVALID;
    wr_word_d   = s_axi.S_AXI_AWADDR[4:2];
    rd_word_d   = s_axi.S_AXI_ARADDR[4:2];
    // A start write may also carry a new op in the same beat; the new op wins.
    op_d        = s_axi.S_AXI_WSTRB[0] ? s_axi.S_AXI_WDATA[1:0] : op_q;
    start_d     = wr_fire_d && (wr_word_d == 3'd2) && s_axi.S_AXI_WSTRB[1] && s_axi.S_AXI_WDATA[8];
    rem_shift_d = {rem_q, quo_q[DW-1]};
    diff_d      = rem_shift_d - {1'b0, b_q};
    case (rd_word_d)
      3'd0:    rd_mux_d = opa_q;
      3'd1:    rd_mux_d = opb_q;
      3'd2:    rd_mux_d = {{(DW-5){1'b0}}, ie_q, 2'b00, op_q};
      3'd3:    rd_mux_d = {{(DW-3){1'b0}}, div0_q, done_q, busy_q};
      3'd4:    rd_mux_d = result_q;
      default: rd_mux_d = '0;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= IDLE;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      op_q      <= '0;
      op_lat_q  <= '0;
      ie_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      awready_q <= ~awready_q & ~bvalid_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
      if (wr_fire_d)                bvalid_q <= 1'b1;
      else if (s_axi.S_AXI_BREADY)  bvalid_q <= 1'b0;

      if (wr_fire_d) begin
        case (wr_word_d)
          3'd0: opa_q <= merge(opa_q, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
          3'd1: opb_q <= merge(opb_q, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
          3'd2: if (s_axi.S_AXI_WSTRB[0]) begin
                  op_q <= s_axi.S_AXI_WDATA[1:0];
                  ie_q <= s_axi.S_AXI_WDATA[4];
                end
          default: ;
        endcase
      end

      arready_q <= ~arready_q & ~rvalid_q & s_axi.S_AXI_ARVALID;
      if (rd_fire_d) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux_d;
      end else if (s_axi.S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end

      case (state_q)
        IDLE: if (start_d) begin
          a_q      <= opa_q;
          b_q      <= opb_q;
          op_lat_q <= op_d;
          quo_q    <= opa_q;
          rem_q    <= '0;
          cnt_q    <= '0;
          busy_q   <= 1'b1;
          done_q   <= 1'b0;
          div0_q   <= 1'b0;
          // Divide by zero takes the single-cycle path and reports div0.
          state_q  <= (op_d == 2'd3 && opb_q != '0) ? DIV : EXEC;
        end
        EXEC: begin
          case (op_lat_q)
            2'd0: result_q <= a_q + b_q;
            2'd1: result_q <= a_q - b_q;
            2'd2: result_q <= a_q * b_q;
            default: begin
              result_q <= '1;
              div0_q   <= 1'b1;
            end
          endcase
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        DIV: begin
          if (cnt_q == CW'(DIV_CYCLES)) begin
            result_q <= quo_q;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end else begin
            if (!diff_d[DW]) begin
              rem_q <= diff_d[DW-1:0];
              quo_q <= {quo_q[DW-2:0], 1'b1};
            end else begin
              rem_q <= rem_shift_d[DW-1:0];
              quo_q <= {quo_q[DW-2:0], 1'b0};
            end
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = awready_q;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign irq                 = done_q & ie_q;

  assign unused_ok = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0],
                       s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, a_q[0]};
endmodule

// File: tb/tb_calc_axil_slave.sv
// tb/tb_calc_axil_slave.sv - directed self-checking bench for calc_axil_slave.
module tb_calc_axil_slave;
  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic irq;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   accept_cyc = 0;

  calc_axil_slave_if bus ();

  calc_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5),
    .DIV_CYCLES(32)
  ) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .s_axi(bus.slave),
    .irq(irq)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic seen;
    seen = 1'b0;
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (bus.S_AXI_AWREADY && bus.S_AXI_WREADY) begin seen = 1'b1; break; end
    end
    check("wr_accept", {31'b0, seen}, 32'd1);
    @(posedge ACLK); #1;
    accept_cyc = cyc;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (bus.S_AXI_BVALID) begin seen = 1'b1; break; end
    end
    check("wr_bresp", {29'b0, ~seen, bus.S_AXI_BRESP}, 32'd0);
    @(posedge ACLK); #1;
    bus.S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
    logic seen;
    seen = 1'b0;
    data = 32'hDEAD_BEEF;
    resp = 2'b11;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (bus.S_AXI_ARREADY) begin seen = 1'b1; break; end
    end
    check("rd_accept", {31'b0, seen}, 32'd1);
    @(posedge ACLK); #1;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (bus.S_AXI_RVALID) begin
        data = bus.S_AXI_RDATA;
        resp = bus.S_AXI_RRESP;
        break;
      end
    end
    @(posedge ACLK); #1;
    bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(addr, d, r);
    check(tag, d, exp);
  endtask

  function automatic logic [31:0] out_flags();
    return {26'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID,
            bus.S_AXI_ARREADY, bus.S_AXI_RVALID, irq};
  endfunction

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic        seen;
    logic        hold_ok;
    int          t0;
    int          n;

    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;

    repeat (3) @(posedge ACLK);
    #1;
    check("reset_flags", out_flags(), 32'd0);
    check("reset_rdata", bus.S_AXI_RDATA, 32'd0);
    ARESET = 1'b0;
    @(posedge ACLK); #1;

    for (int a = 0; a < 8; a++) begin
      axi_read(5'(a * 4), d, r);
      check($sformatf("reset_read_%0d", a), d, 32'd0);
      check($sformatf("reset_rresp_%0d", a), {30'b0, r}, 32'd0);
    end
    check("reset_irq", {31'b0, irq}, 32'd0);

    axi_write(5'h00, 32'd7, 4'hF);
    axi_write(5'h04, 32'd5, 4'hF);
    axi_write(5'h08, 32'h110, 4'hF);
    check("add_irq_next_cycle", {31'b0, irq}, 32'd1);
    read_check("add_status", 5'h0C, 32'h2);
    read_check("add_result", 5'h10, 32'd12);
    read_check("ctrl_readback", 5'h08, 32'h10);

    axi_write(5'h08, 32'h101, 4'hF);
    read_check("sub_result", 5'h10, 32'h2);
    check("sub_irq_ie_off", {31'b0, irq}, 32'd0);
    axi_write(5'h00, 32'd5, 4'hF);
    axi_write(5'h04, 32'd7, 4'hF);
    axi_write(5'h08, 32'h101, 4'hF);
    read_check("sub_wrap", 5'h10, 32'hFFFF_FFFE);

    axi_write(5'h00, 32'h0001_0000, 4'hF);
    axi_write(5'h04, 32'h0001_0003, 4'hF);
    axi_write(5'h08, 32'h102, 4'hF);
    read_check("mul_low", 5'h10, 32'h0003_0000);
    axi_write(5'h04, 32'h0001_0000, 4'hF);
    axi_write(5'h08, 32'h102, 4'hF);
    read_check("mul_overflow", 5'h10, 32'h0);

    axi_write(5'h00, 32'd100, 4'hF);
    axi_write(5'h04, 32'd7, 4'hF);
    axi_write(5'h08, 32'h113, 4'hF);
    t0 = accept_cyc;
    read_check("div_busy_status", 5'h0C, 32'h1);
    axi_write(5'h00, 32'd1, 4'hF);
    axi_write(5'h08, 32'h113, 4'hF);
    check("div_irq_while_busy", {31'b0, irq}, 32'd0);
    n = 0;
    while (!irq && n < 200) begin
      @(posedge ACLK); #1;
      n++;
    end
    check("div_latency", 32'(cyc - t0), 32'd33);
    read_check("div_result", 5'h10, 32'd14);
    read_check("div_status", 5'h0C, 32'h2);
    read_check("opa_written_busy", 5'h00, 32'd1);

    axi_write(5'h04, 32'd0, 4'hF);
    axi_write(5'h08, 32'h113, 4'hF);
    read_check("div0_result", 5'h10, 32'hFFFF_FFFF);
    read_check("div0_status", 5'h0C, 32'h6);

    axi_write(5'h00, 32'hAABB_CCDD, 4'hF);
    axi_write(5'h00, 32'h1122_3344, 4'h5);
    read_check("wstrb_merge", 5'h00, 32'hAA22_CC44);

    bus.S_AXI_AWADDR  = 5'h04;
    bus.S_AXI_WDATA   = 32'h1234;
    bus.S_AXI_WSTRB   = 4'hF;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (bus.S_AXI_AWREADY) begin seen = 1'b1; break; end
    end
    check("hold_first_accept", {31'b0, seen}, 32'd1);
    @(posedge ACLK); #1;
    bus.S_AXI_WDATA = 32'h5678;
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      if (!bus.S_AXI_BVALID || bus.S_AXI_AWREADY || bus.S_AXI_WREADY) hold_ok = 1'b0;
    end
    check("bvalid_hold_no_accept", {31'b0, hold_ok}, 32'd1);
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b1;
    @(posedge ACLK); #1;
    bus.S_AXI_BREADY = 1'b0;
    check("bvalid_cleared", {31'b0, bus.S_AXI_BVALID}, 32'd0);
    read_check("hold_opb", 5'h04, 32'h1234);

    axi_write(5'h00, 32'd100, 4'hF);
    axi_write(5'h04, 32'd7, 4'hF);
    axi_write(5'h08, 32'h113, 4'hF);
    read_check("pre_reset_busy", 5'h0C, 32'h1);
    #2;
    ARESET = 1'b1;
    #1;
    check("midreset_flags", out_flags(), 32'd0);
    check("midreset_rdata", bus.S_AXI_RDATA, 32'd0);
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    read_check("post_reset_status", 5'h0C, 32'h0);
    read_check("post_reset_result", 5'h10, 32'h0);
    n = 0;
    while (n < 40) begin
      @(posedge ACLK); #1;
      n++;
    end
    check("post_reset_no_done", {31'b0, irq}, 32'd0);
    read_check("post_reset_status_late", 5'h0C, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
